// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues in-order reads to instruction memory and
// buffers PC-tagged responses in a shift FIFO toward decode, with redirect flush/drain.
module fetch_queue #(
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [WIDTH-1:0]  RESET_ADDR = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_addr,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  input  logic [WIDTH-1:0] imem_resp_data,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready
);
  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(4);

  typedef enum logic [0:0] {FETCH, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [WIDTH-1:0] pc_q   [DEPTH];
  logic [WIDTH-1:0] pc_d   [DEPTH];

  logic             credit;
  logic             req_fire;
  logic             resp_take;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_idx;
  logic [CNT_W:0]   inflight_sum;

  // Entries in flight plus entries buffered may never exceed the FIFO size.
  assign inflight_sum   = {1'b0, outstanding_q} + {1'b0, count_q};
  assign credit         = inflight_sum < DEPTH_C;
  assign imem_req_valid = reset & (state_q == FETCH) & credit & ~redirect;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign resp_take      = imem_resp_valid & (outstanding_q != '0);
  assign push           = resp_take & (state_q == FETCH) & ~redirect;
  assign pop            = valid_q & instr_ready & ~redirect;
  // Head sits in slot 0; a simultaneous pop shifts the write slot down by one.
  assign wr_idx         = pop ? PTR_W'(count_q - CNT_W'(1)) : PTR_W'(count_q);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_take);
    data_d        = data_q;
    pc_d          = pc_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
    if (push)     resp_pc_d  = resp_pc_q + STEP;
    if (pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        data_d[i] = data_q[i+1];
        pc_d[i]   = pc_q[i+1];
      end
    end
    if (push) begin
      data_d[wr_idx] = imem_resp_data;
      pc_d[wr_idx]   = resp_pc_q;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (redirect) begin
      fetch_pc_d = redirect_addr;
      resp_pc_d  = redirect_addr;
      count_d    = '0;
    end
    unique case (state_q)
      FETCH:   if (redirect && (outstanding_d != '0)) state_d = DRAIN;
      DRAIN:   if (outstanding_d == '0) state_d = FETCH;
      default: state_d = FETCH;
    endcase
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_ADDR;
      resp_pc_q     <= RESET_ADDR;
      outstanding_q <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
      data_q        <= '{default: '0};
      pc_q          <= '{default: '0};
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      pc_q          <= pc_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr_data  = data_q[0];
  assign instr_pc    = pc_q[0];

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: an in-order memory model tracks requests in flight,
// the expected instruction stream is queued and checked by an independent monitor.
module tb_fetch_queue;
  localparam int unsigned DEPTH      = 4;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } instr_t;

  req_t        memq[$];
  instr_t      sb[$];
  logic [31:0] model_pc = RESET_ADDR;
  int          checks = 0;
  int          failures = 0;
  bit          popped_now = 1'b0;

  fetch_queue #(
    .WIDTH(32),
    .DEPTH(DEPTH),
    .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the decode-side outputs against the expected stream.
  initial begin
    bit     first;
    bit     prev_rst;
    instr_t t;
    first    = 1'b1;
    prev_rst = 1'b1;
    forever begin
      @(negedge clock);
      #3;
      popped_now = 1'b0;
      if (!first) begin
        if (!prev_rst) begin
          chk("reset_instr_valid", instr_valid, 0);
          chk("reset_instr_data", instr_data, 0);
          chk("reset_instr_pc", instr_pc, 0);
        end else begin
          chk("instr_valid", instr_valid, sb.size() != 0);
          if (sb.size() != 0) begin
            chk("instr_data", instr_data, sb[0].data);
            chk("instr_pc", instr_pc, sb[0].pc);
            if (instr_ready && !redirect) begin
              t = sb.pop_front();
              popped_now = 1'b1;
            end
          end
        end
      end
      first    = 1'b0;
      prev_rst = reset;
    end
  end

  // One cycle of stimulus plus the reference update at the end of that cycle.
  task automatic step(input bit rst_n, input bit redir, input logic [31:0] raddr,
                      input bit rdy, input bit resp, input bit irdy);
    bit   exp_rv;
    bit   drain;
    int   occ;
    req_t e;
    @(negedge clock);
    reset           = rst_n;
    redirect        = redir;
    redirect_addr   = raddr;
    imem_req_ready  = rdy;
    instr_ready     = irdy;
    imem_resp_valid = resp;
    imem_resp_data  = (memq.size() != 0) ? memq[0].data : $urandom;
    #4;
    if (!rst_n) begin
      chk("req_valid_in_reset", imem_req_valid, 0);
      memq.delete();
      sb.delete();
      model_pc = RESET_ADDR;
    end else begin
      drain = 1'b0;
      foreach (memq[i]) if (memq[i].stale) drain = 1'b1;
      occ    = memq.size() + sb.size() + int'(popped_now);
      exp_rv = !drain && (occ < DEPTH) && !redir;
      chk("imem_req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("imem_req_addr", imem_req_addr, model_pc);
      if (resp && memq.size() != 0) begin
        e = memq.pop_front();
        if (!e.stale && !redir) sb.push_back('{data: e.data, pc: e.addr});
      end
      if (exp_rv && rdy) begin
        memq.push_back('{addr: model_pc, data: $urandom, stale: 1'b0});
        model_pc += 32'd4;
      end
      if (redir) begin
        foreach (memq[i]) memq[i].stale = 1'b1;
        sb.delete();
        model_pc = raddr;
      end
    end
  endtask

  initial begin
    repeat (3) step(0, 0, 32'h0, 0, 0, 0);
    // Back-to-back fetch with one-cycle memory
    repeat (12) step(1, 0, 32'h0, 1, 1, 1);
    // Decode stalled: fill, then a single pop frees exactly one request
    repeat (10) step(1, 0, 32'h0, 1, 1, 0);
    step(1, 0, 32'h0, 1, 1, 1);
    repeat (5) step(1, 0, 32'h0, 1, 1, 0);
    repeat (8) step(1, 0, 32'h0, 0, 1, 1);
    // Two in flight, redirect to 0x100, responses dropped
    repeat (2) step(1, 0, 32'h0, 1, 0, 1);
    step(1, 1, 32'h100, 1, 0, 1);
    repeat (3) step(1, 0, 32'h0, 1, 0, 1);
    repeat (10) step(1, 0, 32'h0, 1, 1, 1);
    // Redirect coinciding with a response and a pop
    repeat (3) step(1, 0, 32'h0, 1, 1, 0);
    step(1, 1, 32'h200, 1, 1, 1);
    repeat (6) step(1, 0, 32'h0, 1, 1, 1);
    // Address wrap past 0xFFFFFFFC
    step(1, 1, 32'hFFFF_FFF8, 1, 1, 1);
    repeat (8) step(1, 0, 32'h0, 1, 1, 1);
    // Reset while draining
    repeat (2) step(1, 0, 32'h0, 1, 0, 1);
    step(1, 1, 32'h300, 1, 0, 1);
    step(1, 0, 32'h0, 1, 0, 1);
    repeat (2) step(0, 0, 32'h0, 1, 1, 1);
    repeat (10) step(1, 0, 32'h0, 1, 1, 1);
    // Randomized traffic with varying decode back-pressure
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ra;
      int          lvl;
      lvl = (n / 150) % 4;
      ra  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                         : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 499) != 0, $urandom_range(0, 24) == 0, ra,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) < lvl);
    end
    repeat (12) step(1, 0, 32'h0, 1, 1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
